// File: rtl/ex_result_retire.sv
// ex_result_retire: retire half of the MIPS32 pipeline.
// Carries EX results through EX/MEM and MEM/WB, drives the data-memory
// and register-file write ports, forwards current operand values back to
// ID/EX, and flags load-use hazards that forwarding cannot cover.
module ex_result_retire (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] EX_ALUResult,
    input  logic [4:0]  EX_WriteRegister,
    input  logic        EX_RegWrite,
    input  logic        EX_MemRead,
    input  logic        EX_MemWrite,
    input  logic [31:0] EX_StoreData,
    input  logic [31:0] DM_ReadData,
    output logic [31:0] DM_Addr,
    output logic [31:0] DM_WriteData,
    output logic        DM_MemWrite,
    output logic        DM_MemRead,
    output logic [31:0] WB_WriteData,
    output logic [4:0]  WB_WriteRegister,
    output logic        WB_RegWrite,
    input  logic [4:0]  ID_rs,
    input  logic [4:0]  ID_rt,
    input  logic [31:0] ID_rs_rf,
    input  logic [31:0] ID_rt_rf,
    output logic [31:0] FWD_rs_val,
    output logic [31:0] FWD_rt_val,
    output logic        Stall
);

    // EX/MEM fields
    logic [31:0] r_m_alu_result;
    logic [4:0]  r_m_write_register;
    logic        r_m_reg_write;
    logic        r_m_mem_read;
    logic        r_m_mem_write;
    logic [31:0] r_m_store_data;

    // MEM/WB fields
    logic [31:0] r_w_result;
    logic [4:0]  r_w_write_register;
    logic        r_w_reg_write;

    logic [31:0] w_m_result;
    logic        w_ex_fwd_ok;
    logic        w_ex_rs_hit;
    logic        w_ex_rt_hit;
    logic        w_m_rs_hit;
    logic        w_m_rt_hit;
    logic        w_w_rs_hit;
    logic        w_w_rt_hit;

    // EX/MEM register; writes to $0 are dropped here so no later stage sees them
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_m_alu_result     <= 32'd0;
            r_m_write_register <= 5'd0;
            r_m_reg_write      <= 1'b0;
            r_m_mem_read       <= 1'b0;
            r_m_mem_write      <= 1'b0;
            r_m_store_data     <= 32'd0;
        end else begin
            r_m_alu_result     <= EX_ALUResult;
            r_m_write_register <= EX_WriteRegister;
            r_m_reg_write      <= EX_RegWrite && (EX_WriteRegister != 5'd0);
            r_m_mem_read       <= EX_MemRead;
            r_m_mem_write      <= EX_MemWrite;
            r_m_store_data     <= EX_StoreData;
        end
    end

    // MEM stage: memory port and the value this stage will retire
    assign DM_Addr      = r_m_alu_result;
    assign DM_WriteData = r_m_store_data;
    assign DM_MemWrite  = r_m_mem_write;
    assign DM_MemRead   = r_m_mem_read;
    assign w_m_result   = r_m_mem_read ? DM_ReadData : r_m_alu_result;

    // MEM/WB register
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_w_result         <= 32'd0;
            r_w_write_register <= 5'd0;
            r_w_reg_write      <= 1'b0;
        end else begin
            r_w_result         <= w_m_result;
            r_w_write_register <= r_m_write_register;
            r_w_reg_write      <= r_m_reg_write;
        end
    end

    assign WB_WriteData     = r_w_result;
    assign WB_WriteRegister = r_w_write_register;
    assign WB_RegWrite      = r_w_reg_write;

    // A load in EX has no data yet, so only non-load EX results may forward
    assign w_ex_fwd_ok = EX_RegWrite && !EX_MemRead;

    assign w_ex_rs_hit = w_ex_fwd_ok   && (ID_rs != 5'd0) && (ID_rs == EX_WriteRegister);
    assign w_ex_rt_hit = w_ex_fwd_ok   && (ID_rt != 5'd0) && (ID_rt == EX_WriteRegister);
    assign w_m_rs_hit  = r_m_reg_write && (ID_rs != 5'd0) && (ID_rs == r_m_write_register);
    assign w_m_rt_hit  = r_m_reg_write && (ID_rt != 5'd0) && (ID_rt == r_m_write_register);
    assign w_w_rs_hit  = r_w_reg_write && (ID_rs != 5'd0) && (ID_rs == r_w_write_register);
    assign w_w_rt_hit  = r_w_reg_write && (ID_rt != 5'd0) && (ID_rt == r_w_write_register);

    // Forwarding: youngest producer wins; WB covers a register file that is not write-first
    always_comb begin
        FWD_rs_val = ID_rs_rf;
        if (w_ex_rs_hit) begin
            FWD_rs_val = EX_ALUResult;
        end else if (w_m_rs_hit) begin
            FWD_rs_val = w_m_result;
        end else if (w_w_rs_hit) begin
            FWD_rs_val = r_w_result;
        end

        FWD_rt_val = ID_rt_rf;
        if (w_ex_rt_hit) begin
            FWD_rt_val = EX_ALUResult;
        end else if (w_m_rt_hit) begin
            FWD_rt_val = w_m_result;
        end else if (w_w_rt_hit) begin
            FWD_rt_val = r_w_result;
        end
    end

    // Load-use hazard: one bubble lets the load reach MEM, where its data forwards
    assign Stall = EX_MemRead && EX_RegWrite && (EX_WriteRegister != 5'd0) &&
                   ((EX_WriteRegister == ID_rs) || (EX_WriteRegister == ID_rt));

endmodule

// File: tb/tb_ex_result_retire.sv
// Testbench for ex_result_retire: directed cycle table followed by
// randomized traffic checked against an in-flight instruction history model.
module tb_ex_result_retire;

    logic        Clk;
    logic        Rst;
    logic [31:0] EX_ALUResult;
    logic [4:0]  EX_WriteRegister;
    logic        EX_RegWrite;
    logic        EX_MemRead;
    logic        EX_MemWrite;
    logic [31:0] EX_StoreData;
    logic [31:0] DM_ReadData;
    logic [31:0] DM_Addr;
    logic [31:0] DM_WriteData;
    logic        DM_MemWrite;
    logic        DM_MemRead;
    logic [31:0] WB_WriteData;
    logic [4:0]  WB_WriteRegister;
    logic        WB_RegWrite;
    logic [4:0]  ID_rs;
    logic [4:0]  ID_rt;
    logic [31:0] ID_rs_rf;
    logic [31:0] ID_rt_rf;
    logic [31:0] FWD_rs_val;
    logic [31:0] FWD_rt_val;
    logic        Stall;

    int total = 0;
    int bad   = 0;

    ex_result_retire dut (
        .Clk(Clk), .Rst(Rst),
        .EX_ALUResult(EX_ALUResult), .EX_WriteRegister(EX_WriteRegister),
        .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead),
        .EX_MemWrite(EX_MemWrite), .EX_StoreData(EX_StoreData),
        .DM_ReadData(DM_ReadData), .DM_Addr(DM_Addr),
        .DM_WriteData(DM_WriteData), .DM_MemWrite(DM_MemWrite),
        .DM_MemRead(DM_MemRead), .WB_WriteData(WB_WriteData),
        .WB_WriteRegister(WB_WriteRegister), .WB_RegWrite(WB_RegWrite),
        .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_rs_rf(ID_rs_rf), .ID_rt_rf(ID_rt_rf),
        .FWD_rs_val(FWD_rs_val), .FWD_rt_val(FWD_rt_val), .Stall(Stall)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Data memory contents as a pure function of address
    function automatic logic [31:0] rd_mem(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return {a[15:0], a[31:16]} ^ 32'h5A5A0F0F;
    endfunction

    assign DM_ReadData = rd_mem(DM_Addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        rst, adv, rw, mr, mw;
        logic [4:0]  wr;
        logic [31:0] alu, sd;
        logic [4:0]  rs, rt;
        logic [31:0] rs_rf, rt_rf;
        logic [31:0] e_rs, e_rt;
        logic        e_stall, e_wrw;
        logic [4:0]  e_wwr;
        logic [31:0] e_wd;
        logic        e_dmw, e_dmr;
        logic [31:0] e_addr, e_dwd;
    } vec_t;

    function automatic vec_t v(
        input logic rst, adv, rw, mr, mw, input logic [4:0] wr,
        input logic [31:0] alu, sd, input logic [4:0] rs, rt,
        input logic [31:0] rs_rf, rt_rf, e_rs, e_rt,
        input logic e_stall, e_wrw, input logic [4:0] e_wwr, input logic [31:0] e_wd,
        input logic e_dmw, e_dmr, input logic [31:0] e_addr, e_dwd);
        vec_t r;
        r.rst = rst; r.adv = adv; r.rw = rw; r.mr = mr; r.mw = mw; r.wr = wr;
        r.alu = alu; r.sd = sd; r.rs = rs; r.rt = rt; r.rs_rf = rs_rf; r.rt_rf = rt_rf;
        r.e_rs = e_rs; r.e_rt = e_rt; r.e_stall = e_stall; r.e_wrw = e_wrw;
        r.e_wwr = e_wwr; r.e_wd = e_wd; r.e_dmw = e_dmw; r.e_dmr = e_dmr;
        r.e_addr = e_addr; r.e_dwd = e_dwd;
        return r;
    endfunction

    localparam int NV = 21;
    vec_t tbl[NV];

    // ---------------- reference model ----------------
    typedef struct {
        logic        rw, mr, mw;
        logic [4:0]  wr;
        logic [31:0] alu, sd;
    } rec_t;

    rec_t pipe[$];   // pipe[0] = oldest in flight (WB), pipe[1] = MEM

    function automatic logic writes(input rec_t e);
        return e.rw && (e.wr != 5'd0);
    endfunction

    function automatic logic [31:0] result_of(input rec_t e);
        return e.mr ? rd_mem(e.alu) : e.alu;
    endfunction

    // Newest visible producer of idx, else the register-file value
    function automatic logic [31:0] model_fwd(input rec_t ex, input logic [4:0] idx,
                                              input logic [31:0] rf);
        if (idx == 5'd0) return rf;
        if (writes(ex) && !ex.mr && ex.wr == idx) return ex.alu;
        if (writes(pipe[1]) && pipe[1].wr == idx) return result_of(pipe[1]);
        if (writes(pipe[0]) && pipe[0].wr == idx) return result_of(pipe[0]);
        return rf;
    endfunction

    task automatic drive(input logic rst, rw, mr, mw, input logic [4:0] wr,
                         input logic [31:0] alu, sd, input logic [4:0] rs, rt,
                         input logic [31:0] rs_rf, rt_rf);
        Rst = rst; EX_RegWrite = rw; EX_MemRead = mr; EX_MemWrite = mw;
        EX_WriteRegister = wr; EX_ALUResult = alu; EX_StoreData = sd;
        ID_rs = rs; ID_rt = rt; ID_rs_rf = rs_rf; ID_rt_rf = rt_rf;
    endtask

    initial begin
        rec_t zero;
        rec_t cur;
        logic [31:0] e_rs, e_rt;
        logic        e_stall;

        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0, 32'd0, 32'd0);

        //            rst adv rw mr mw wr     alu           sd            rs     rt     rs_rf         rt_rf          e_rs          e_rt          st wrw wwr    wd                    dmw dmr addr         dwd
        tbl[0]  = v(0, 1, 1, 0, 1, 5'd5,  32'h10,       32'h1,        5'd0,  5'd0,  32'h0,        32'h0,         32'h0,        32'h0,        0, 0, 5'd0,  32'h0,                0, 0, 32'h0,       32'h0);
        tbl[1]  = v(0, 1, 1, 1, 1, 5'd5,  32'h10,       32'h1,        5'd5,  5'd0,  32'hAB,       32'h0,         32'hAB,       32'h0,        1, 0, 5'd0,  32'h0,                0, 0, 32'h0,       32'h0);
        tbl[2]  = v(1, 1, 1, 0, 0, 5'd8,  32'h5,        32'h0,        5'd8,  5'd0,  32'h77,       32'h0,         32'h5,        32'h0,        0, 0, 5'd0,  32'h0,                0, 0, 32'h0,       32'h0);
        tbl[3]  = v(1, 1, 0, 0, 0, 5'd0,  32'h0,        32'h0,        5'd8,  5'd0,  32'h77,       32'h0,         32'h5,        32'h0,        0, 0, 5'd0,  32'h0,                0, 0, 32'h5,       32'h0);
        tbl[4]  = v(1, 1, 0, 0, 0, 5'd0,  32'h0,        32'h0,        5'd8,  5'd0,  32'h77,       32'h0,         32'h5,        32'h0,        0, 1, 5'd8,  32'h5,                0, 0, 32'h0,       32'h0);
        tbl[5]  = v(1, 1, 0, 0, 0, 5'd0,  32'h0,        32'h0,        5'd8,  5'd0,  32'h77,       32'h0,         32'h77,       32'h0,        0, 0, 5'd0,  32'h0,                0, 0, 32'h0,       32'h0);
        tbl[6]  = v(1, 1, 1, 1, 0, 5'd9,  32'h100,      32'h0,        5'd0,  5'd9,  32'h0,        32'h11,        32'h0,        32'h11,       1, 0, 5'd0,  32'h0,                0, 0, 32'h0,       32'h0);
        tbl[7]  = v(1, 1, 0, 0, 0, 5'd0,  32'h0,        32'h0,        5'd0,  5'd9,  32'h0,        32'h11,        32'h0,        32'hDEADBEEF, 0, 0, 5'd0,  32'h0,                0, 1, 32'h100,     32'h0);
        tbl[8]  = v(1, 1, 1, 1, 0, 5'd0,  32'h1234,     32'h0,        5'd0,  5'd0,  32'h0,        32'h0,         32'h0,        32'h0,        0, 1, 5'd9,  32'hDEADBEEF,         0, 0, 32'h0,       32'h0);
        tbl[9]  = v(1, 1, 0, 0, 0, 5'd0,  32'h0,        32'h0,        5'd0,  5'd0,  32'h0,        32'h0,         32'h0,        32'h0,        0, 0, 5'd0,  32'h0,                0, 1, 32'h1234,    32'h0);
        tbl[10] = v(1, 1, 0, 0, 0, 5'd0,  32'h0,        32'h0,        5'd0,  5'd0,  32'h0,        32'h0,         32'h0,        32'h0,        0, 0, 5'd0,  rd_mem(32'h1234),     0, 0, 32'h0,       32'h0);
        tbl[11] = v(1, 1, 1, 0, 0, 5'd10, 32'h4,        32'h0,        5'd10, 5'd10, 32'h99,       32'h99,        32'h4,        32'h4,        0, 0, 5'd0,  32'h0,                0, 0, 32'h0,       32'h0);
        tbl[12] = v(1, 1, 1, 0, 0, 5'd10, 32'h3,        32'h0,        5'd10, 5'd10, 32'h99,       32'h99,        32'h3,        32'h3,        0, 0, 5'd0,  32'h0,                0, 0, 32'h4,       32'h0);
        tbl[13] = v(1, 0, 1, 0, 0, 5'd10, 32'h2,        32'h0,        5'd10, 5'd10, 32'h99,       32'h99,        32'h2,        32'h2,        0, 1, 5'd10, 32'h4,                0, 0, 32'h3,       32'h0);
        tbl[14] = v(1, 1, 0, 0, 0, 5'd0,  32'h0,        32'h0,        5'd10, 5'd10, 32'h99,       32'h99,        32'h3,        32'h3,        0, 1, 5'd10, 32'h4,                0, 0, 32'h3,       32'h0);
        tbl[15] = v(1, 1, 0, 0, 0, 5'd0,  32'h0,        32'h0,        5'd10, 5'd10, 32'h99,       32'h99,        32'h3,        32'h3,        0, 1, 5'd10, 32'h3,                0, 0, 32'h0,       32'h0);
        tbl[16] = v(1, 1, 0, 0, 1, 5'd0,  32'h40,       32'hCAFE,     5'd0,  5'd0,  32'h0,        32'h0,         32'h0,        32'h0,        0, 0, 5'd0,  32'h0,                0, 0, 32'h0,       32'h0);
        tbl[17] = v(1, 1, 1, 0, 1, 5'd7,  32'h60,       32'h55,       5'd0,  5'd0,  32'h0,        32'h0,         32'h0,        32'h0,        0, 0, 5'd0,  32'h0,                1, 0, 32'h40,      32'hCAFE);
        tbl[18] = v(0, 1, 1, 0, 1, 5'd7,  32'h50,       32'h77,       5'd0,  5'd0,  32'h0,        32'h0,         32'h0,        32'h0,        0, 0, 5'd0,  32'h40,               1, 0, 32'h60,      32'h55);
        tbl[19] = v(1, 1, 0, 0, 0, 5'd0,  32'h0,        32'h0,        5'd0,  5'd0,  32'h0,        32'h0,         32'h0,        32'h0,        0, 0, 5'd0,  32'h0,                0, 0, 32'h0,       32'h0);
        tbl[20] = v(1, 1, 0, 0, 0, 5'd0,  32'h0,        32'h0,        5'd0,  5'd0,  32'h0,        32'h0,         32'h0,        32'h0,        0, 0, 5'd0,  32'h0,                0, 0, 32'h0,       32'h0);

        for (int i = 0; i < NV; i++) begin
            if (i == 0 || tbl[i-1].adv) @(negedge Clk);
            else #1;
            drive(tbl[i].rst, tbl[i].rw, tbl[i].mr, tbl[i].mw, tbl[i].wr, tbl[i].alu,
                  tbl[i].sd, tbl[i].rs, tbl[i].rt, tbl[i].rs_rf, tbl[i].rt_rf);
            #1;
            chk($sformatf("t%0d fwd_rs", i), FWD_rs_val, tbl[i].e_rs);
            chk($sformatf("t%0d fwd_rt", i), FWD_rt_val, tbl[i].e_rt);
            chk($sformatf("t%0d stall", i), {31'd0, Stall}, {31'd0, tbl[i].e_stall});
            chk($sformatf("t%0d wb_regwrite", i), {31'd0, WB_RegWrite}, {31'd0, tbl[i].e_wrw});
            chk($sformatf("t%0d wb_wreg", i), {27'd0, WB_WriteRegister}, {27'd0, tbl[i].e_wwr});
            chk($sformatf("t%0d wb_wdata", i), WB_WriteData, tbl[i].e_wd);
            chk($sformatf("t%0d dm_memwrite", i), {31'd0, DM_MemWrite}, {31'd0, tbl[i].e_dmw});
            chk($sformatf("t%0d dm_memread", i), {31'd0, DM_MemRead}, {31'd0, tbl[i].e_dmr});
            chk($sformatf("t%0d dm_addr", i), DM_Addr, tbl[i].e_addr);
            chk($sformatf("t%0d dm_wdata", i), DM_WriteData, tbl[i].e_dwd);
        end

        // Last table row was a bubble after a bubble, so both stages now hold zeros
        zero = '{rw: 1'b0, mr: 1'b0, mw: 1'b0, wr: 5'd0, alu: 32'd0, sd: 32'd0};
        pipe.delete();
        pipe.push_back(zero);
        pipe.push_back(zero);

        // ---------------- randomized phase ----------------
        for (int n = 0; n < 1500; n++) begin
            @(negedge Clk);
            cur.rw  = 1'($urandom_range(0, 1));
            cur.mr  = ($urandom_range(0, 3) == 0);
            cur.mw  = ($urandom_range(0, 3) == 0);
            cur.wr  = 5'($urandom_range(0, 3));
            cur.alu = ($urandom_range(0, 7) == 0) ? 32'h100 : $urandom;
            cur.sd  = $urandom;
            Rst              = ($urandom_range(0, 31) != 0);
            EX_RegWrite      = cur.rw;
            EX_MemRead       = cur.mr;
            EX_MemWrite      = cur.mw;
            EX_WriteRegister = cur.wr;
            EX_ALUResult     = cur.alu;
            EX_StoreData     = cur.sd;
            ID_rs            = 5'($urandom_range(0, 3));
            ID_rt            = 5'($urandom_range(0, 3));
            ID_rs_rf         = (ID_rs == 5'd0) ? 32'd0 : $urandom;
            ID_rt_rf         = (ID_rt == 5'd0) ? 32'd0 : $urandom;
            #1;
            e_rs    = model_fwd(cur, ID_rs, ID_rs_rf);
            e_rt    = model_fwd(cur, ID_rt, ID_rt_rf);
            e_stall = cur.mr && writes(cur) && (cur.wr == ID_rs || cur.wr == ID_rt);
            chk("r fwd_rs", FWD_rs_val, e_rs);
            chk("r fwd_rt", FWD_rt_val, e_rt);
            chk("r stall", {31'd0, Stall}, {31'd0, e_stall});
            chk("r dm_addr", DM_Addr, pipe[1].alu);
            chk("r dm_wdata", DM_WriteData, pipe[1].sd);
            chk("r dm_memwrite", {31'd0, DM_MemWrite}, {31'd0, pipe[1].mw});
            chk("r dm_memread", {31'd0, DM_MemRead}, {31'd0, pipe[1].mr});
            chk("r wb_regwrite", {31'd0, WB_RegWrite}, {31'd0, writes(pipe[0])});
            chk("r wb_wreg", {27'd0, WB_WriteRegister}, {27'd0, pipe[0].wr});
            chk("r wb_wdata", WB_WriteData, result_of(pipe[0]));
            @(posedge Clk);
            if (!Rst) begin
                pipe.delete();
                pipe.push_back(zero);
                pipe.push_back(zero);
            end else begin
                pipe.push_back(cur);
                void'(pipe.pop_front());
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net: the bench must always end on its own
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
